// File: rtl/vector_serializer_if.sv
// Handshake and word-stream bundle for vector_serializer.
// The slave modport is the serializer; the master modport is its environment.
interface vector_serializer_if #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 7
);
    localparam int BW = $clog2(OUT_WIDTH + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  long_vector_in;
    logic                 fifo_full;
    logic [OUT_WIDTH-1:0] short_vector_out;
    logic                 short_vector_out_valid;
    logic                 short_vector_out_last;
    logic [BW-1:0]        short_vector_out_bits;
    logic                 done;

    modport master (
        output in_valid,
        output long_vector_in,
        output fifo_full,
        input  in_ready,
        input  short_vector_out,
        input  short_vector_out_valid,
        input  short_vector_out_last,
        input  short_vector_out_bits,
        input  done
    );

    modport slave (
        input  in_valid,
        input  long_vector_in,
        input  fifo_full,
        output in_ready,
        output short_vector_out,
        output short_vector_out_valid,
        output short_vector_out_last,
        output short_vector_out_bits,
        output done
    );
endinterface

// File: rtl/vector_serializer.sv
// Splits a wide vector into OUT_WIDTH words behind a one-deep holding buffer,
// so the next vector can be reloaded on the last-word cycle with no bubble.
module vector_serializer #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 7,
    parameter int MSB_FIRST = 1
) (
    input  logic clock,
    input  logic reset,
    vector_serializer_if.slave bus
);
    localparam int NWORDS    = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int LAST_BITS = IN_WIDTH - (NWORDS - 1) * OUT_WIDTH;
    localparam int SW        = NWORDS * OUT_WIDTH;
    localparam int CW        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int BW        = $clog2(OUT_WIDTH + 1);

    localparam logic [CW-1:0] LAST_CNT = CW'(NWORDS - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_n;
    logic                hold_full;
    logic                hold_full_n;
    logic [IN_WIDTH-1:0] hold_data;
    logic [SW-1:0]       shift_q;
    logic [SW-1:0]       shift_n;
    logic [SW-1:0]       load_vec;
    logic [SW-1:0]       shifted;
    logic [OUT_WIDTH-1:0] word;
    logic                done_q;
    logic                done_n;
    logic                accept;
    logic                xfer;
    logic                is_last;
    logic                load;

    // The shift register is padded to a whole number of words; the pad
    // sits away from the emit end so the short last word lands emit-aligned.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign load_vec = SW'(hold_data) << (SW - IN_WIDTH);
            assign shifted  = shift_q << OUT_WIDTH;
            assign word     = shift_q[SW-1 -: OUT_WIDTH];
        end else begin : g_lsb
            assign load_vec = SW'(hold_data);
            assign shifted  = shift_q >> OUT_WIDTH;
            assign word     = shift_q[OUT_WIDTH-1:0];
        end
    endgenerate

    assign accept  = bus.in_valid && bus.in_ready;
    assign is_last = (state == S_SHIFT) && (count == LAST_CNT);
    assign xfer    = (state == S_SHIFT) && !bus.fifo_full;
    assign load    = hold_full && ((state == S_IDLE) || (xfer && is_last));

    assign hold_full_n = accept || (hold_full && !load);

    always_comb begin
        state_n = state;
        count_n = count;
        shift_n = shift_q;
        done_n  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (hold_full) begin
                    state_n = S_SHIFT;
                    count_n = '0;
                    shift_n = load_vec;
                end
            end
            S_SHIFT: begin
                if (xfer) begin
                    if (is_last) begin
                        done_n = 1'b1;
                        if (hold_full) begin
                            count_n = '0;
                            shift_n = load_vec;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        count_n = count + CW'(1);
                        shift_n = shifted;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= '0;
            hold_full <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            hold_full <= hold_full_n;
            done_q    <= done_n;
        end
    end

    // Data registers carry no reset; control state alone decides validity.
    always_ff @(posedge clock) begin
        shift_q <= shift_n;
        if (accept) begin
            hold_data <= bus.long_vector_in;
        end
    end

    assign bus.in_ready               = !hold_full && !reset;
    assign bus.short_vector_out       = word;
    assign bus.short_vector_out_valid = xfer && !reset;
    assign bus.short_vector_out_last  = is_last;
    assign bus.short_vector_out_bits  = (state == S_IDLE) ? '0 :
                                        is_last ? BW'(LAST_BITS) :
                                        BW'(OUT_WIDTH);
    assign bus.done                   = done_q && !reset;
endmodule

// File: tb/tb_vector_serializer.sv
// Randomised bench for vector_serializer against a per-bit reference model.
module tb_vector_serializer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vector_serializer_if #(.IN_WIDTH(128), .OUT_WIDTH(7)) ia ();
    vector_serializer_if #(.IN_WIDTH(16), .OUT_WIDTH(4)) ib ();

    vector_serializer #(.IN_WIDTH(128), .OUT_WIDTH(7), .MSB_FIRST(1)) dut_a (
        .clock(clk), .reset(reset), .bus(ia)
    );
    vector_serializer #(.IN_WIDTH(16), .OUT_WIDTH(4), .MSB_FIRST(0)) dut_b (
        .clock(clk), .reset(reset), .bus(ib)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [6:0] aw[$];
    int         ab[$];
    logic       al[$];
    int         ac[$];
    int         ad[$];
    logic [6:0] ew[$];
    int         eb[$];
    logic       el[$];
    logic [3:0] bw[$];
    int         bb[$];
    logic       bl[$];
    int         bd = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ia.short_vector_out_valid === 1'b1) begin
            aw.push_back(ia.short_vector_out);
            ab.push_back(int'(ia.short_vector_out_bits));
            al.push_back(ia.short_vector_out_last);
            ac.push_back(cyc);
        end
        if (ia.done === 1'b1) ad.push_back(cyc);
        if (ib.short_vector_out_valid === 1'b1) begin
            bw.push_back(ib.short_vector_out);
            bb.push_back(int'(ib.short_vector_out_bits));
            bl.push_back(ib.short_vector_out_last);
        end
        if (ib.done === 1'b1) bd++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word i, MSB first: bit j of the word (from its top) is vector bit
    // 127-(7i+j), or zero once past bit 0.
    task automatic model_a(input logic [127:0] v);
        for (int i = 0; i < 19; i++) begin
            logic [6:0] w;
            int rem;
            w = '0;
            for (int j = 0; j < 7; j++) begin
                int idx;
                idx = 127 - (i * 7 + j);
                if (idx >= 0) w[6-j] = v[idx];
            end
            rem = 128 - i * 7;
            ew.push_back(w);
            eb.push_back(rem < 7 ? rem : 7);
            el.push_back(i == 18);
        end
    endtask

    task automatic clear_a();
        aw.delete(); ab.delete(); al.delete(); ac.delete(); ad.delete();
        ew.delete(); eb.delete(); el.delete();
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic offer_a(input logic [127:0] v, output int acc);
        acc = -1;
        ia.in_valid = 1'b1;
        ia.long_vector_in = v;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (ia.in_ready === 1'b1) begin
                acc = cyc;
                step();
                break;
            end
            step();
        end
        ia.in_valid = 1'b0;
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL accept_timeout got none required accept");
        end
    endtask

    task automatic wait_done_a(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (ad.size() >= n) break;
            step();
        end
        step();
        step();
        checks++;
        if (ad.size() != n) begin
            errors++;
            $display("FAIL done_count got %0d required %0d", ad.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ia.in_valid = 1'b0; ia.fifo_full = 1'b0; ia.long_vector_in = '0;
        ib.in_valid = 1'b0; ib.fifo_full = 1'b0; ib.long_vector_in = '0;
        step(); step(); step();
        @(negedge clk);
        checks++;
        if (ia.in_ready !== 1'b0 || ib.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b/%b required 0", ia.in_ready, ib.in_ready);
        end
        checks++;
        if (ia.short_vector_out_valid !== 1'b0 || ia.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_done got %b/%b required 0/0",
                     ia.short_vector_out_valid, ia.done);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ia.in_ready !== 1'b1 || ib.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready got %b/%b required 1", ia.in_ready, ib.in_ready);
        end
        checks++;
        if (ia.short_vector_out_bits !== 3'd0 || ia.short_vector_out_last !== 1'b0 ||
            ia.short_vector_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs got bits=%0d last=%b valid=%b required 0/0/0",
                     ia.short_vector_out_bits, ia.short_vector_out_last,
                     ia.short_vector_out_valid);
        end
        step();
    endtask

    task automatic test_single();
        logic [127:0] v;
        logic [6:0]   top;
        int           acc;
        clear_a();
        v = 128'h0123456789ABCDEF0123456789ABCDEF;
        top = v[127:121];
        model_a(v);
        offer_a(v, acc);
        wait_done_a(1, 60);
        checks++;
        if (aw.size() != 19) begin
            errors++;
            $display("FAIL single_count got %0d required 19", aw.size());
        end
        for (int i = 0; i < aw.size() && i < ew.size(); i++) begin
            checks++;
            if (aw[i] !== ew[i] || ab[i] !== eb[i] || al[i] !== el[i]) begin
                errors++;
                $display("FAIL single_word%0d got %h/%0d/%b required %h/%0d/%b",
                         i, aw[i], ab[i], al[i], ew[i], eb[i], el[i]);
            end
        end
        if (aw.size() > 0) begin
            checks++;
            if (aw[0] !== top) begin
                errors++;
                $display("FAIL single_first got %h required %h", aw[0], top);
            end
        end
        if (ad.size() > 0 && ac.size() == 19) begin
            checks++;
            if (ad[0] != ac[18] + 1) begin
                errors++;
                $display("FAIL single_done_cycle got %0d required %0d", ad[0], ac[18] + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] v1, v2;
        int c1, c2;
        clear_a();
        v1 = rand128();
        v2 = rand128();
        model_a(v1);
        model_a(v2);
        offer_a(v1, c1);
        offer_a(v2, c2);
        wait_done_a(2, 120);
        checks++;
        if (aw.size() != 38) begin
            errors++;
            $display("FAIL b2b_count got %0d required 38", aw.size());
        end
        for (int i = 0; i < aw.size() && i < ew.size(); i++) begin
            checks++;
            if (aw[i] !== ew[i] || ab[i] !== eb[i] || al[i] !== el[i]) begin
                errors++;
                $display("FAIL b2b_word%0d got %h/%0d/%b required %h/%0d/%b",
                         i, aw[i], ab[i], al[i], ew[i], eb[i], el[i]);
            end
        end
        for (int i = 1; i < ac.size(); i++) begin
            checks++;
            if (ac[i] != ac[i-1] + 1) begin
                errors++;
                $display("FAIL b2b_gap at %0d got cycle %0d required %0d",
                         i, ac[i], ac[i-1] + 1);
            end
        end
        if (ad.size() > 0) begin
            checks++;
            if (!(c2 > c1 && c2 < ad[0])) begin
                errors++;
                $display("FAIL b2b_overlap got accept %0d required before %0d", c2, ad[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] v;
        logic [6:0]   pw;
        logic         pff, pbusy;
        int           acc;
        clear_a();
        v = rand128();
        model_a(v);
        ia.fifo_full = 1'b0;
        offer_a(v, acc);
        pff = 1'b0; pbusy = 1'b0; pw = '0;
        for (int k = 0; k < 400; k++) begin
            ia.fifo_full = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (ia.fifo_full) begin
                checks++;
                if (ia.short_vector_out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_valid got %b required 0", ia.short_vector_out_valid);
                end
            end
            if (pff && pbusy) begin
                checks++;
                if (ia.short_vector_out !== pw) begin
                    errors++;
                    $display("FAIL bp_frozen got %h required %h", ia.short_vector_out, pw);
                end
            end
            pff = ia.fifo_full;
            pbusy = (ia.short_vector_out_bits != 0);
            pw = ia.short_vector_out;
            step();
            if (ad.size() >= 1) break;
        end
        ia.fifo_full = 1'b0;
        wait_done_a(1, 40);
        checks++;
        if (aw.size() != 19) begin
            errors++;
            $display("FAIL bp_count got %0d required 19", aw.size());
        end
        for (int i = 0; i < aw.size() && i < ew.size(); i++) begin
            checks++;
            if (aw[i] !== ew[i] || ab[i] !== eb[i] || al[i] !== el[i]) begin
                errors++;
                $display("FAIL bp_word%0d got %h/%0d/%b required %h/%0d/%b",
                         i, aw[i], ab[i], al[i], ew[i], eb[i], el[i]);
            end
        end
    endtask

    task automatic test_lsb();
        logic [15:0] v;
        logic [3:0]  e;
        bit          got;
        bw.delete(); bb.delete(); bl.delete(); bd = 0;
        v = 16'hABCD;
        got = 1'b0;
        ib.in_valid = 1'b1;
        ib.long_vector_in = v;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ib.in_ready === 1'b1) begin
                got = 1'b1;
                step();
                break;
            end
            step();
        end
        ib.in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bd >= 1) break;
            step();
        end
        step(); step();
        checks++;
        if (!got || bw.size() != 4 || bd != 1) begin
            errors++;
            $display("FAIL lsb_count got accept=%b words=%0d done=%0d required 1/4/1",
                     got, bw.size(), bd);
        end
        for (int i = 0; i < bw.size() && i < 4; i++) begin
            e = 4'((v >> (4 * i)) & 16'hF);
            checks++;
            if (bw[i] !== e || bb[i] !== 4 || bl[i] !== (i == 3)) begin
                errors++;
                $display("FAIL lsb_word%0d got %h/%0d/%b required %h/4/%b",
                         i, bw[i], bb[i], bl[i], e, (i == 3));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] v1, v2, v3;
        int c;
        clear_a();
        v1 = rand128();
        v2 = rand128();
        v3 = rand128();
        offer_a(v1, c);
        offer_a(v2, c);
        for (int k = 0; k < 40; k++) begin
            if (aw.size() >= 5) break;
            step();
        end
        checks++;
        if (aw.size() != 5) begin
            errors++;
            $display("FAIL rst_mid_words got %0d required 5", aw.size());
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (ia.short_vector_out_valid !== 1'b0 || ia.in_ready !== 1'b0 ||
                ia.done !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_outputs got valid=%b ready=%b done=%b required 0/0/0",
                         ia.short_vector_out_valid, ia.in_ready, ia.done);
            end
            step();
        end
        reset = 1'b0;
        aw.delete(); ab.delete(); al.delete(); ac.delete();
        for (int k = 0; k < 30; k++) step();
        checks++;
        if (aw.size() != 0 || ad.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_residue got words=%0d done=%0d required 0/0",
                     aw.size(), ad.size());
        end
        clear_a();
        model_a(v3);
        offer_a(v3, c);
        wait_done_a(1, 60);
        checks++;
        if (aw.size() != 19) begin
            errors++;
            $display("FAIL rst_mid_count got %0d required 19", aw.size());
        end
        for (int i = 0; i < aw.size() && i < ew.size(); i++) begin
            checks++;
            if (aw[i] !== ew[i] || ab[i] !== eb[i] || al[i] !== el[i]) begin
                errors++;
                $display("FAIL rst_mid_word%0d got %h/%0d/%b required %h/%0d/%b",
                         i, aw[i], ab[i], al[i], ew[i], eb[i], el[i]);
            end
        end
    endtask

    task automatic test_hold_full();
        logic [127:0] v1, v2, v3;
        int c, c3;
        clear_a();
        v1 = rand128();
        v2 = rand128();
        v3 = rand128();
        model_a(v1);
        model_a(v2);
        model_a(v3);
        ia.fifo_full = 1'b1;
        offer_a(v1, c);
        offer_a(v2, c);
        ia.in_valid = 1'b1;
        ia.long_vector_in = v3;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if (ia.in_ready !== 1'b0 || ia.short_vector_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_stall got ready=%b valid=%b required 0/0",
                         ia.in_ready, ia.short_vector_out_valid);
            end
            step();
        end
        ia.fifo_full = 1'b0;
        c3 = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ia.in_ready === 1'b1) begin
                c3 = cyc;
                step();
                break;
            end
            step();
        end
        ia.in_valid = 1'b0;
        wait_done_a(3, 150);
        checks++;
        if (ac.size() < 19 || c3 != ac[18] + 1) begin
            errors++;
            $display("FAIL hold_third_accept got %0d required cycle after v1 last",
                     c3);
        end
        checks++;
        if (aw.size() != 57) begin
            errors++;
            $display("FAIL hold_count got %0d required 57", aw.size());
        end
        for (int i = 0; i < aw.size() && i < ew.size(); i++) begin
            checks++;
            if (aw[i] !== ew[i] || ab[i] !== eb[i] || al[i] !== el[i]) begin
                errors++;
                $display("FAIL hold_word%0d got %h/%0d/%b required %h/%0d/%b",
                         i, aw[i], ab[i], al[i], ew[i], eb[i], el[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_lsb();
        test_reset_mid();
        test_hold_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
